// File: rtl/proc_pipe_pkg.sv
// Shared types for the processor pipeline stage buffers.
package proc_pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf_ctrl.sv
// Occupancy state machine for the two-entry skid buffer; produces the
// handshake outputs and the payload register load enables.
module pipe_skid_ctrl
  import proc_pipe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic ld_main,
  output logic ld_skid,
  output logic sel_skid
);

  skid_state_t state_q, state_d;
  logic        push, pop;

  // Both handshake outputs decode straight from the state flop.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    sel_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = BUSY;
            ld_main = 1'b1;
          end
        end
        BUSY: begin
          if (push && !pop) begin
            state_d = FULL;
            ld_skid = 1'b1;
          end else if (push && pop) begin
            ld_main = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d  = BUSY;
            ld_main  = 1'b1;
            sel_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer between pipeline stages. Optional
// back-pressure counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_buf
  import proc_pipe_pkg::*;
#(
  parameter int                 DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic              ld_main, ld_skid, sel_skid;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;

  pipe_skid_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .ld_main   (ld_main),
    .ld_skid   (ld_skid),
    .sel_skid  (sel_skid)
  );

  // Draining FULL promotes the skid entry, which keeps FIFO order.
  assign main_d   = sel_skid ? skid_q : in_data;
  assign out_data = main_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      if (ld_main) main_q <= main_d;
      if (ld_skid) skid_q <= in_data;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating; only reset clears it so flushes do not hide stall history.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (out_valid && !out_ready && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: doc/pipe_skid_buf.md
Name: pipe_skid_buf

Overview:
- Two-entry valid/ready skid buffer placed between processor pipeline stages (e.g. decode -> execute).
- Acts as the consumer-side end of the stage handshake: it accepts producer data, holds it under downstream back-pressure, and releases it to the next stage.
- Breaks the combinational ready path so upstream stall is fully registered.
- Sustains one transfer per cycle.

Parameters:
- DATA_W, 32, width of the payload word.
- RESET_VAL, 0, value loaded into the payload registers on reset; out_data shows this value after reset.
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; drops all held entries.
- in_valid  input  1  producer presents in_data.
- in_data  input  DATA_W  producer payload.
- in_ready  output  1  buffer can accept; registered, decoded from state only.
- out_valid  output  1  out_data is valid.
- out_data  output  DATA_W  payload to next stage; driven from the main register.
- out_ready  input  1  consumer accepts this cycle.
- stall_cnt  output  CNT_W  back-pressure cycle count; present only with the macro.

Behaviour:
- Handshake terms:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Data must stay stable while valid is high and ready is low; the block guarantees this on the out side.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - BUSY: main register holds data; out_valid=1, in_ready=1.
  - FULL: main and skid registers both hold data; out_valid=1, in_ready=0.
- Transitions:
  - EMPTY: push -> BUSY, main<=in_data. Otherwise stay.
  - BUSY, push & !pop: -> FULL, skid<=in_data.
  - BUSY, push & pop: stay BUSY, main<=in_data.
  - BUSY, pop & !push: -> EMPTY.
  - BUSY, neither: stay; main holds.
  - FULL, pop: -> BUSY, main<=skid. No push is possible because in_ready=0.
  - FULL, !pop: stay; both registers hold.
- Latency and throughput:
  - A word pushed in cycle N is on out_data in cycle N+1 if the buffer was EMPTY, or BUSY with a pop in cycle N.
  - Throughput is one word per cycle with out_ready held high.
- Ordering: strict FIFO. The skid entry never overtakes the main entry.
- Priority: reset > flush > normal operation.
- Reset:
  - State goes to EMPTY.
  - main and skid registers load RESET_VAL.
  - out_valid=0, in_ready=1 in the first cycle after reset.
  - stall_cnt=0.
  - Reset mid-transfer discards both entries; no pop is reported.
- Flush:
  - State goes to EMPTY next cycle; payload registers keep their values.
  - A push or pop coinciding with flush is discarded (the consumer's pop is still taken as completed).
  - in_ready=1 after flush.
- in_valid while in_ready=0 is ignored; the producer must hold its data.
- out_data while out_valid=0 shows the last main value or RESET_VAL; it is don't-care to consumers.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at all-ones.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and counter logic are absent. Handshake behaviour is identical.

Decomposition:
- Shared package proc_pipe_pkg:
  - skid_state_t enum {EMPTY, BUSY, FULL}, 2-bit encoding.
  - Localparam DEFAULT_DATA_W=32.
- One sub-module, pipe_skid_ctrl:
  - State register plus next-state logic.
  - Produces in_ready, out_valid, and load enables for the main register, the skid register, and the main<=skid select.
- The top level holds the payload registers and the optional counter.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, in_ready=1, out_data=RESET_VAL, stall_cnt=0. No word is captured.
- Streaming: out_ready=1, push 0x1, 0x2, 0x3 on consecutive cycles -> out_data 0x1, 0x2, 0x3 on cycles N+1..N+3, in_ready constantly 1.
- Back-pressure: out_ready=0, push 0xA then 0xB -> state FULL and in_ready=0 next cycle; 0xC held on in_data is not accepted. Raise out_ready -> outputs 0xA, then 0xB, then accepts 0xC, in order with no loss.
- Flush in FULL: buffer holds 0xA/0xB, assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, in_ready=1; 0xC is never output.
- Simultaneous push and pop in BUSY: main=0x5, push 0x6 with out_ready=1 -> 0x5 consumed, out_data=0x6 next cycle, state stays BUSY.
- With PIPE_SKID_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10. With CNT_W=4 and 20 stall cycles -> stall_cnt=15 (saturated).
